slave_port_arbiter: RTL and testbench
=====================================

Name: slave_port_arbiter

Overview:
- Sits in front of one crossbar slave and shares it between two masters (m0, m1).
- Filters requests by address bit 31 and arbitrates round-robin. Forwards one transaction at a time on the slave-side req/cmd/addr/wdata bus, tracks the slave's ack, and returns a single-cycle completion or error pulse with read data to the owning master.
- A timeout releases the slave if the slave never answers.

Parameters:
- ADDR, 1'b0, slave select; a master request targets this port when addr[31] == ADDR.
- TIMEOUT, 16, cycles allowed in BUSY+ACKED before abort; legal range 2..255.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack or m0_err.
- m0_cmd  in  1  1 = write, 0 = read.
- m0_addr  in  32  address.
- m0_wdata  in  32  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  one-cycle timeout pulse.
- m0_rdata  out  32  read data, held until next read completion for m0.
- m1_req, m1_cmd, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0, for master 1.
- s_req  out  1  request to slave.
- s_cmd  out  1  latched command.
- s_addr  out  32  latched address.
- s_wdata  out  32  latched write data.
- s_ack  in  1  slave acknowledge; may stay high several cycles.
- s_rdata  in  32  slave read data, valid the first cycle s_ack is low after its high phase.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, checked every edge, overrides everything):
  - state = IDLE, last = 1 (m0 wins the first tie), timeout counter = 0.
  - All outputs 0, including both rdata registers and the s_* bus.
  - Reset mid-transaction abandons it: s_req is low the cycle after reset is sampled, and no ack or err is issued.
- Eligibility: mN is eligible when mN_req && mN_addr[31] == ADDR. Ineligible requests are ignored and never acked.
- States: IDLE, BUSY, ACKED, DONE, ERR. All outputs are registered.
- IDLE:
  - One eligible master: grant it.
  - Both eligible: grant the master != last.
  - On grant: owner <= index; s_cmd, s_addr, s_wdata <= the owner's inputs; counter <= 0; go to BUSY.
  - Latency: req sampled at edge t gives s_req high from t+1.
- BUSY:
  - s_req = 1 and the s_* bus is stable. Counter increments.
  - s_ack = 1: go to ACKED; s_req falls on the same edge.
  - Otherwise, counter == TIMEOUT-1: go to ERR.
- ACKED:
  - s_req = 0. Counter keeps incrementing.
  - s_ack = 0: capture s_rdata into the owner's rdata if s_cmd == 0; go to DONE.
  - Otherwise, counter == TIMEOUT-1: go to ERR.
- DONE: owner's ack = 1 for exactly this cycle; last <= owner; go to IDLE.
- ERR: owner's err = 1 for exactly this cycle; rdata unchanged; last <= owner; go to IDLE.
- Simultaneous events:
  - Ack arriving on the timeout cycle: the ack transition wins over ERR.
  - Requests arriving while busy wait; there is no queue beyond the held req.
- Master contract: the master drops req the cycle after ack or err, or keeps it high to request a new transaction, which is then re-arbitrated in IDLE.
- Master inputs change only while that master is not owner or is in IDLE; the latched copies make mid-transaction changes harmless.
- Minimum transaction length: 4 cycles (IDLE, BUSY, ACKED, DONE), one transaction in flight at a time.
- Non-owner ack, err and rdata stay at their previous values (ack and err = 0).

Test Plan:
- Read from m0, ADDR=0, m0_addr=0x0000_0010, slave returns 0x1234 after ack falls → s_addr=0x10, s_cmd=0; m0_ack pulses once; m0_rdata=0x1234; m1 outputs unchanged.
- Both masters assert read continuously with addr[31]=0 after reset → grant order m0, m1, m0, m1; each ack is a single pulse; busy low exactly one cycle between transactions.
- m1 write of 0xDEAD_BEEF with m1_rdata previously 0x5 → s_wdata=0xDEAD_BEEF, s_cmd=1, m1_ack pulses, m1_rdata stays 0x5.
- m0_addr=0x8000_0000 with ADDR=0 → s_req never rises, no ack, busy stays 0.
- Slave holds s_ack=0 with TIMEOUT=16 → m0_err pulses exactly 16 cycles after BUSY is entered; no m0_ack; next request is served normally.
- Reset asserted during ACKED → next cycle all outputs 0, state IDLE; a subsequent tie goes to m0.

Source files
------------

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter
// Shares one crossbar slave between two masters (m0, m1). Requests are
// filtered by address bit 31, arbitrated round-robin, and forwarded one at a
// time on a latched slave bus. The slave's ack is tracked through its high
// and low phases, and the owning master gets a single-cycle ack (with read
// data) or, if the slave never answers in time, a single-cycle err.
// Every output is driven straight from a register.

module slave_port_arbiter #(
    parameter logic ADDR    = 1'b0,
    parameter int   TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_cmd,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_cmd,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_cmd,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,

    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY  = 3'd1,
        ACKED = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Last counter value at which the slave may still answer; one more
    // silent cycle and the transaction is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        elig0, elig1;
    logic        grant;

    logic        s_req_q, s_req_d;
    logic        s_cmd_q, s_cmd_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        busy_q, busy_d;

    // A master only competes for this port when its address selects it.
    assign elig0 = m0_req && (m0_addr[31] == ADDR);
    assign elig1 = m1_req && (m1_addr[31] == ADDR);

    // State register plus every registered output; reset abandons any
    // transaction in flight without pulsing ack or err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            s_req_q   <= 1'b0;
            s_cmd_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            s_req_q   <= s_req_d;
            s_cmd_q   <= s_cmd_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic: round-robin grant in IDLE, ack tracking and timeout
    // while the slave owns the transaction. An ack seen on the timeout cycle
    // is checked first so it wins over the abort.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    grant   = 1'b1;
                    owner_d = ~last_q;
                end else if (elig0) begin
                    grant   = 1'b1;
                    owner_d = 1'b0;
                end else if (elig1) begin
                    grant   = 1'b1;
                    owner_d = 1'b1;
                end
                if (grant) begin
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (s_ack) begin
                    state_d = ACKED;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ERR;
                end
            end
            ACKED: begin
                cnt_d = cnt_q + 8'd1;
                if (!s_ack) begin
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            ERR: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: computes the next value of each registered output from
    // the transition being taken, so outputs line up with the new state.
    always_comb begin
        s_req_d   = (state_d == BUSY);
        s_cmd_d   = s_cmd_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        ack_d     = '0;
        err_d     = '0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        busy_d    = (state_d != IDLE);

        if (grant) begin
            if (owner_d) begin
                s_cmd_d   = m1_cmd;
                s_addr_d  = m1_addr;
                s_wdata_d = m1_wdata;
            end else begin
                s_cmd_d   = m0_cmd;
                s_addr_d  = m0_addr;
                s_wdata_d = m0_wdata;
            end
        end

        if ((state_q == ACKED) && (state_d == DONE)) begin
            ack_d[owner_q] = 1'b1;
            if (!s_cmd_q) begin
                if (owner_q) begin
                    rdata1_d = s_rdata;
                end else begin
                    rdata0_d = s_rdata;
                end
            end
        end

        if (state_d == ERR) begin
            err_d[owner_q] = 1'b1;
        end
    end

    assign s_req    = s_req_q;
    assign s_cmd    = s_cmd_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb_slave_port_arbiter
// Directed bench for slave_port_arbiter with a transaction-level reference
// model compared against every output each cycle, a small reactive slave,
// and hand-computed literal expectations for each scenario.

module tb_slave_port_arbiter;

    localparam logic ADDR    = 1'b0;
    localparam int   TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_cmd = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_cmd = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        s_req, s_cmd;
    logic [31:0] s_addr, s_wdata;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    slave_port_arbiter #(.ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reactive slave: waits slaveDelay cycles of s_req, holds ack for ackLen
    // cycles, then presents slaveData on the first cycle ack is low.
    bit          slaveMute  = 1'b0;
    int          slaveDelay = 0;
    int          ackLen     = 1;
    logic [31:0] slaveData  = '0;
    int          slvWait    = 0;
    int          slvHold    = 0;

    always @(negedge clk) begin
        if (reset) begin
            s_ack   = 1'b0;
            slvWait = slaveDelay;
        end else if (s_ack) begin
            if (slvHold > 1) begin
                slvHold--;
            end else begin
                s_ack   = 1'b0;
                s_rdata = slaveData;
            end
        end else if (s_req && !slaveMute) begin
            if (slvWait <= 0) begin
                s_ack   = 1'b1;
                slvHold = ackLen;
                s_rdata = 32'hFFFF_FFFF;
            end else begin
                slvWait--;
            end
        end else begin
            slvWait = slaveDelay;
        end
    end

    // Transaction-level reference: who holds the slave, whether its ack has
    // been seen, how long it has been waiting, and whether the completion
    // pulse is on the wire this cycle.
    int          mOwner   = -1;
    bit          mAcked   = 1'b0;
    bit          mClosing = 1'b0;
    int          mAge     = 0;
    bit          mLast    = 1'b1;
    logic        eSReq, eSCmd, eBusy;
    logic [31:0] eSAddr, eSWdata;
    logic [1:0]  eAck, eErr;
    logic [31:0] eRdata [2];

    task automatic modelStep();
        bit want0, want1;
        int pick;
        if (reset) begin
            mOwner = -1; mAcked = 0; mClosing = 0; mAge = 0; mLast = 1;
            eSReq = 0; eSCmd = 0; eSAddr = '0; eSWdata = '0;
            eAck = '0; eErr = '0; eRdata[0] = '0; eRdata[1] = '0; eBusy = 0;
            return;
        end
        eAck = '0;
        eErr = '0;
        if (mClosing) begin
            mClosing = 0;
            mOwner   = -1;
            eBusy    = 0;
        end else if (mOwner < 0) begin
            want0 = m0_req && (m0_addr[31] == ADDR);
            want1 = m1_req && (m1_addr[31] == ADDR);
            pick  = -1;
            if (want0 && want1) pick = mLast ? 0 : 1;
            else if (want0)     pick = 0;
            else if (want1)     pick = 1;
            if (pick >= 0) begin
                mOwner  = pick;
                mAge    = 0;
                mAcked  = 0;
                eSReq   = 1;
                eBusy   = 1;
                eSCmd   = (pick == 0) ? m0_cmd   : m1_cmd;
                eSAddr  = (pick == 0) ? m0_addr  : m1_addr;
                eSWdata = (pick == 0) ? m0_wdata : m1_wdata;
            end
        end else begin
            if (!mAcked && s_ack) begin
                mAcked = 1;
                eSReq  = 0;
            end else if (mAcked && !s_ack) begin
                if (!eSCmd) eRdata[mOwner] = s_rdata;
                eAck[mOwner] = 1'b1;
                mLast    = (mOwner == 1);
                mClosing = 1;
            end else if (mAge == TIMEOUT - 1) begin
                eErr[mOwner] = 1'b1;
                eSReq    = 0;
                mLast    = (mOwner == 1);
                mClosing = 1;
            end
            mAge = (mAge + 1) % 256;
        end
    endtask

    always @(posedge clk) begin
        cycle++;
        modelStep();
    end

    // Compare process plus event monitors used by the literal checks.
    int ackLog[$];
    bit test2On = 0, test4On = 0;
    int idleGaps = 0, ineligHits = 0;
    int busyRise = 0, errAt = 0;
    bit prevBusy = 0;

    always @(posedge clk) begin
        #1;
        checkOutput("s_req",    s_req,    eSReq);
        checkOutput("s_cmd",    s_cmd,    eSCmd);
        checkOutput("s_addr",   s_addr,   eSAddr);
        checkOutput("s_wdata",  s_wdata,  eSWdata);
        checkOutput("busy",     busy,     eBusy);
        checkOutput("m0_ack",   m0_ack,   eAck[0]);
        checkOutput("m1_ack",   m1_ack,   eAck[1]);
        checkOutput("m0_err",   m0_err,   eErr[0]);
        checkOutput("m1_err",   m1_err,   eErr[1]);
        checkOutput("m0_rdata", m0_rdata, eRdata[0]);
        checkOutput("m1_rdata", m1_rdata, eRdata[1]);
        if (test2On && ackLog.size() >= 1 && ackLog.size() < 4 && !busy) idleGaps++;
        if (m0_ack) ackLog.push_back(0);
        if (m1_ack) ackLog.push_back(1);
        if (busy && !prevBusy) busyRise = cycle;
        if (m0_err) errAt = cycle;
        if (test4On && (s_req || busy || m0_ack || m0_err)) ineligHits++;
        prevBusy = busy;
    end

    // Drive one master's request and hold it until ack or err (bounded).
    // outcome: 1 = ack, 2 = err, 0 = nothing within the budget.
    task automatic applyStimulus(input int m, input bit cmd, input logic [31:0] addr,
                                 input logic [31:0] wd, output int outcome);
        @(negedge clk);
        if (m == 0) begin
            m0_req = 1; m0_cmd = cmd; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = 1; m1_cmd = cmd; m1_addr = addr; m1_wdata = wd;
        end
        outcome = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin outcome = 1; break; end
            if ((m == 0) ? m0_err : m1_err) begin outcome = 2; break; end
        end
        if (m == 0) m0_req = 0; else m1_req = 0;
        checkOutput("completion_in_time", (outcome != 0), 1);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1; m0_req = 0; m1_req = 0;
        repeat (3) @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int outcome;
        logic [3:0] seq;

        repeat (3) @(negedge clk);
        reset = 0;
        checkOutput("reset_busy",  busy,  0);
        checkOutput("reset_s_req", s_req, 0);

        // Single m0 read
        slaveData = 32'h0000_1234;
        applyStimulus(0, 0, 32'h0000_0010, 32'h0, outcome);
        checkOutput("t1_outcome",  outcome,  1);
        checkOutput("t1_s_addr",   s_addr,   32'h10);
        checkOutput("t1_s_cmd",    s_cmd,    0);
        checkOutput("t1_m0_rdata", m0_rdata, 32'h1234);
        checkOutput("t1_m1_rdata", m1_rdata, 32'h0);

        // Both masters stream reads from a fresh reset: strict alternation
        applyReset();
        ackLog.delete();
        idleGaps = 0;
        test2On = 1;
        slaveData = 32'hA5A5_0001;
        @(negedge clk);
        m0_req = 1; m0_cmd = 0; m0_addr = 32'h20;
        m1_req = 1; m1_cmd = 0; m1_addr = 32'h24;
        for (int i = 0; i < 80 && ackLog.size() < 4; i++) @(negedge clk);
        m0_req = 0; m1_req = 0;
        test2On = 0;
        checkOutput("t2_ack_count", ackLog.size(), 4);
        seq = '0;
        foreach (ackLog[i]) if (i < 4) seq = {seq[2:0], ackLog[i][0]};
        checkOutput("t2_grant_order", seq, 4'b0101);
        checkOutput("t2_idle_gaps", idleGaps, 3);

        // m1 write must not disturb previously read m1 data
        slaveData = 32'h0000_0005;
        applyStimulus(1, 0, 32'h0000_0100, 32'h0, outcome);
        checkOutput("t3_read_rdata", m1_rdata, 32'h5);
        slaveData = 32'h0000_0077;
        applyStimulus(1, 1, 32'h0000_0104, 32'hDEAD_BEEF, outcome);
        checkOutput("t3_outcome",  outcome,  1);
        checkOutput("t3_s_wdata",  s_wdata,  32'hDEAD_BEEF);
        checkOutput("t3_s_cmd",    s_cmd,    1);
        checkOutput("t3_m1_rdata", m1_rdata, 32'h5);

        // Address for the other port is never served
        ineligHits = 0;
        test4On = 1;
        @(negedge clk);
        m0_req = 1; m0_cmd = 0; m0_addr = 32'h8000_0000;
        repeat (20) @(negedge clk);
        m0_req = 0;
        test4On = 0;
        checkOutput("t4_inelig_activity", ineligHits, 0);

        // Silent slave: err exactly TIMEOUT cycles after BUSY, then recovery
        slaveMute = 1;
        applyStimulus(0, 0, 32'h0000_0030, 32'h0, outcome);
        checkOutput("t5_outcome", outcome, 2);
        checkOutput("t5_err_delay", errAt - busyRise, 16);
        slaveMute = 0;
        slaveData = 32'h0000_0042;
        applyStimulus(0, 0, 32'h0000_0034, 32'h0, outcome);
        checkOutput("t5_recover", outcome, 1);
        checkOutput("t5_recover_rdata", m0_rdata, 32'h42);

        // Ack arriving on the timeout cycle wins over the abort
        slaveDelay = 15;
        slaveData  = 32'h0000_0099;
        applyStimulus(1, 0, 32'h0000_0040, 32'h0, outcome);
        checkOutput("t6_ack_wins", outcome, 1);
        checkOutput("t6_rdata", m1_rdata, 32'h99);
        slaveDelay = 0;

        // Reset during ACKED clears everything; next tie goes to m0
        ackLen = 6;
        @(negedge clk);
        m0_req = 1; m0_cmd = 0; m0_addr = 32'h50;
        outcome = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy && !s_req) begin outcome = 1; break; end
        end
        checkOutput("t7_reached_acked", outcome, 1);
        reset = 1; m0_req = 0;
        @(negedge clk);
        checkOutput("t7_s_req",    s_req,    0);
        checkOutput("t7_busy",     busy,     0);
        checkOutput("t7_m0_rdata", m0_rdata, 0);
        checkOutput("t7_m1_rdata", m1_rdata, 0);
        checkOutput("t7_s_addr",   s_addr,   0);
        repeat (2) @(negedge clk);
        reset = 0;
        ackLen = 1;
        slaveData = 32'h0000_00AB;
        @(negedge clk);
        m0_req = 1; m0_cmd = 0; m0_addr = 32'h60;
        m1_req = 1; m1_cmd = 0; m1_addr = 32'h64;
        outcome = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin outcome = 1; break; end
        end
        checkOutput("t7_first_ack_m0", {m0_ack, m1_ack}, 2'b10);
        m0_req = 0; m1_req = 0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
